// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: access size codes, read/write and
// boolean encodings, FSM state encoding and a size-normalisation helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_ILL  = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IF = 2'b01,
    ST_BUSY_LS = 2'b10
  } arb_state_e;

  // The reserved size code is issued downstream as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_ILL) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, LSU and downstream-sequencer handshakes around the arbiter.
// slave = arbiter side, master = requesters plus sequencer side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_pc;
  logic              if_flush;
  logic              if_ok;
  logic [DATA_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_inst_pc;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic              dn_req;
  logic              dn_we;
  logic [1:0]        dn_size;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_wdata;
  logic              dn_done;
  logic [DATA_W-1:0] dn_rdata;

  modport slave (
    input  if_req, if_pc, if_flush,
    output if_ok, if_inst, if_inst_pc,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_done, ls_rdata,
    output dn_req, dn_we, dn_size, dn_addr, dn_wdata,
    input  dn_done, dn_rdata
  );

  modport master (
    output if_req, if_pc, if_flush,
    input  if_ok, if_inst, if_inst_pc,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_done, ls_rdata,
    input  dn_req, dn_we, dn_size, dn_addr, dn_wdata,
    output dn_done, dn_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_perf_cnt.sv
// Grant and stall event counters for the arbiter; present only when MEM_ARB_PERF_EN
// is defined. Counters wrap on overflow.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_grant_i,
  input  logic             ls_grant_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] perf_if_grants_o,
  output logic [CNT_W-1:0] perf_ls_grants_o,
  output logic [CNT_W-1:0] perf_stall_cycles_o
);
  logic [CNT_W-1:0] if_cnt_q, ls_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt_q    <= '0;
      ls_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (if_grant_i) if_cnt_q    <= if_cnt_q + 1'b1;
      if (ls_grant_i) ls_cnt_q    <= ls_cnt_q + 1'b1;
      if (stall_i)    stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign perf_if_grants_o    = if_cnt_q;
  assign perf_ls_grants_o    = ls_cnt_q;
  assign perf_stall_cycles_o = stall_cnt_q;
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares the byte-serial RAM sequencer between instruction fetch and load/store, one
// request outstanding. Optional perf counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_if_grants,
  output logic [CNT_W-1:0] perf_ls_grants,
  output logic [CNT_W-1:0] perf_stall_cycles
`endif
);
  localparam int             SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  LIMIT_C = SW'(STARVE_LIMIT);

  arb_state_e        state_q;
  logic              kill_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              dn_req_q, dn_we_q;
  logic [1:0]        dn_size_q;
  logic [ADDR_W-1:0] dn_addr_q;
  logic [DATA_W-1:0] dn_wdata_q;
  logic              if_ok_q, ls_done_q;
  logic [DATA_W-1:0] if_inst_q, ls_rdata_q, ls_rdata_d;
  logic [ADDR_W-1:0] if_inst_pc_q;
  logic              if_eligible, force_if, grant_if, grant_ls;

  always_comb begin
    // A flush in the same cycle cancels the fetch request before it can win.
    if_eligible = bus.if_req && !bus.if_flush;
    force_if    = if_eligible && (starve_q == LIMIT_C);
    grant_ls    = (state_q == ST_IDLE) && bus.ls_req && !force_if;
    grant_if    = (state_q == ST_IDLE) && if_eligible && !grant_ls;

    starve_d = starve_q;
    if (!bus.if_req || grant_if)
      starve_d = '0;
    else if (grant_ls && (starve_q != LIMIT_C))
      starve_d = starve_q + 1'b1;

    // Load data is returned zero-extended to the issued access size.
    case (dn_size_q)
      SIZE_BYTE: ls_rdata_d = {{(DATA_W-8){1'b0}}, bus.dn_rdata[7:0]};
      SIZE_HALF: ls_rdata_d = {{(DATA_W-16){1'b0}}, bus.dn_rdata[15:0]};
      default:   ls_rdata_d = bus.dn_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kill_q       <= FALSE;
      starve_q     <= '0;
      dn_req_q     <= FALSE;
      dn_we_q      <= FALSE;
      dn_size_q    <= '0;
      dn_addr_q    <= '0;
      dn_wdata_q   <= '0;
      if_ok_q      <= FALSE;
      if_inst_q    <= '0;
      if_inst_pc_q <= '0;
      ls_done_q    <= FALSE;
      ls_rdata_q   <= '0;
    end else begin
      dn_req_q  <= FALSE;
      if_ok_q   <= FALSE;
      ls_done_q <= FALSE;
      starve_q  <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_ls) begin
            dn_req_q   <= TRUE;
            dn_we_q    <= (bus.ls_we == WRITE);
            dn_size_q  <= norm_size(bus.ls_size);
            dn_addr_q  <= bus.ls_addr;
            dn_wdata_q <= bus.ls_wdata;
            state_q    <= ST_BUSY_LS;
          end else if (grant_if) begin
            dn_req_q   <= TRUE;
            dn_we_q    <= READ;
            dn_size_q  <= SIZE_WORD;
            dn_addr_q  <= bus.if_pc;
            dn_wdata_q <= '0;
            state_q    <= ST_BUSY_IF;
          end
        end
        ST_BUSY_IF: begin
          if (bus.if_flush) kill_q <= TRUE;
          if (bus.dn_done) begin
            if (!kill_q && !bus.if_flush) begin
              if_ok_q      <= TRUE;
              if_inst_q    <= bus.dn_rdata;
              if_inst_pc_q <= dn_addr_q;
            end
            kill_q  <= FALSE;
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY_LS: begin
          if (bus.dn_done) begin
            ls_done_q  <= TRUE;
            ls_rdata_q <= ls_rdata_d;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.dn_req     = dn_req_q;
  assign bus.dn_we      = dn_we_q;
  assign bus.dn_size    = dn_size_q;
  assign bus.dn_addr    = dn_addr_q;
  assign bus.dn_wdata   = dn_wdata_q;
  assign bus.if_ok      = if_ok_q;
  assign bus.if_inst    = if_inst_q;
  assign bus.if_inst_pc = if_inst_pc_q;
  assign bus.ls_done    = ls_done_q;
  assign bus.ls_rdata   = ls_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic stall;
  assign stall = (bus.if_req || bus.ls_req) && !(grant_if || grant_ls);

  mem_arb_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk                 (clk),
    .rst                 (rst),
    .if_grant_i          (grant_if),
    .ls_grant_i          (grant_ls),
    .stall_i             (stall),
    .perf_if_grants_o    (perf_if_grants),
    .perf_ls_grants_o    (perf_ls_grants),
    .perf_stall_cycles_o (perf_stall_cycles)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized phase against a transaction-level model
// of the arbitration rules; inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if, perf_ls, perf_stall;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_grants    (perf_if),
    .perf_ls_grants    (perf_ls),
    .perf_stall_cycles (perf_stall)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dn_req"}, bus.dn_req, 0);
    chk({tag, "_dn_we"}, bus.dn_we, 0);
    chk({tag, "_dn_size"}, bus.dn_size, 0);
    chk({tag, "_dn_addr"}, bus.dn_addr, 0);
    chk({tag, "_dn_wdata"}, bus.dn_wdata, 0);
    chk({tag, "_if_ok"}, bus.if_ok, 0);
    chk({tag, "_if_inst"}, bus.if_inst, 0);
    chk({tag, "_if_inst_pc"}, bus.if_inst_pc, 0);
    chk({tag, "_ls_done"}, bus.ls_done, 0);
    chk({tag, "_ls_rdata"}, bus.ls_rdata, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Randomized-phase model state: who owns the sequencer, LSU wins in a row while IF waits.
  int          owner, cd, streak, n_ls, granted;
  logic        if_seen, if_pend, ls_pend;
  logic        exp_dn_req, exp_if_ok, exp_ls_done, exp_we;
  logic [1:0]  exp_size, own_size;
  logic [31:0] exp_addr, exp_wdata, own_pc, exp_inst, exp_inst_pc, exp_rdata, mask;

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_pc = 0; bus.if_flush = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.dn_done = 0; bus.dn_rdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single fetch, completion five cycles after issue.
    bus.if_req = 1; bus.if_pc = 32'h100;
    tick();
    chk("if_issue_req", bus.dn_req, 1);
    chk("if_issue_size", bus.dn_size, 2'b11);
    chk("if_issue_we", bus.dn_we, 0);
    chk("if_issue_addr", bus.dn_addr, 32'h100);
    tick();
    chk("if_issue_pulse", bus.dn_req, 0);
    tick(); tick(); tick();
    bus.dn_done = 1; bus.dn_rdata = 32'h00A00093;
    tick();
    bus.dn_done = 0; bus.if_req = 0;
    chk("if_ok", bus.if_ok, 1);
    chk("if_inst", bus.if_inst, 32'h00A00093);
    chk("if_inst_pc", bus.if_inst_pc, 32'h100);
    chk("ls_done_idle", bus.ls_done, 0);
    tick();
    chk("if_ok_pulse", bus.if_ok, 0);

    // Simultaneous requests: LSU first, then IF.
    bus.if_req = 1; bus.if_pc = 32'h104;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'b11; bus.ls_addr = 32'h1000;
    tick();
    chk("both_first_addr", bus.dn_addr, 32'h1000);
    chk("both_first_req", bus.dn_req, 1);
    bus.dn_done = 1; bus.dn_rdata = 32'hDEADBEEF;
    tick();
    bus.dn_done = 0; bus.ls_req = 0;
    chk("both_ls_done", bus.ls_done, 1);
    chk("both_ls_rdata", bus.ls_rdata, 32'hDEADBEEF);
    tick();
    chk("both_second_req", bus.dn_req, 1);
    chk("both_second_addr", bus.dn_addr, 32'h104);
    bus.dn_done = 1; bus.dn_rdata = 32'h13;
    tick();
    bus.dn_done = 0; bus.if_req = 0;
    chk("both_if_ok", bus.if_ok, 1);
    tick();

    // Sustained LSU traffic with a waiting fetch: bounded number of LSU wins.
    bus.if_req = 1; bus.if_pc = 32'h400;
    bus.ls_req = 1; bus.ls_addr = 32'h2000;
    n_ls = 0; if_seen = 0;
    for (int c = 0; c < 60 && !if_seen; c++) begin
      tick();
      if (bus.dn_req) begin
        if (bus.dn_addr == 32'h400) if_seen = 1;
        else begin
          n_ls++;
          bus.dn_done = 1;
          tick();
          bus.dn_done = 0;
        end
      end
    end
    chk("starve_if_granted", if_seen, 1);
    chk("starve_ls_grants", n_ls, LIMIT);
    bus.ls_req = 0;
    bus.dn_done = 1;
    tick();
    bus.dn_done = 0; bus.if_req = 0;
    chk("starve_if_ok", bus.if_ok, 1);
    tick();

    // Flush in IDLE suppresses that cycle's fetch request.
    bus.if_req = 1; bus.if_pc = 32'h600; bus.if_flush = 1;
    tick();
    bus.if_req = 0; bus.if_flush = 0;
    chk("flush_idle_no_req", bus.dn_req, 0);
    tick();
    chk("flush_idle_still_none", bus.dn_req, 0);

    // Flush coincident with completion drops the response.
    bus.if_req = 1; bus.if_pc = 32'h500;
    tick();
    chk("flushdone_issue", bus.dn_req, 1);
    tick();
    bus.dn_done = 1; bus.dn_rdata = 32'h55; bus.if_flush = 1; bus.if_req = 0;
    tick();
    bus.dn_done = 0; bus.if_flush = 0;
    chk("flushdone_no_if_ok", bus.if_ok, 0);
    tick();

    // Flush two cycles after issue, then a fresh fetch is served normally.
    bus.if_req = 1; bus.if_pc = 32'h300;
    tick();
    chk("flush_issue", bus.dn_req, 1);
    tick(); tick();
    bus.if_flush = 1; bus.if_req = 0;
    tick();
    bus.if_flush = 0;
    tick();
    bus.dn_done = 1; bus.dn_rdata = 32'h77;
    tick();
    bus.dn_done = 0;
    chk("flush_no_if_ok", bus.if_ok, 0);
    bus.if_req = 1; bus.if_pc = 32'h200;
    tick();
    chk("refetch_req", bus.dn_req, 1);
    chk("refetch_addr", bus.dn_addr, 32'h200);
    bus.dn_done = 1; bus.dn_rdata = 32'h0000_0013;
    tick();
    bus.dn_done = 0; bus.if_req = 0;
    chk("refetch_if_ok", bus.if_ok, 1);
    chk("refetch_inst_pc", bus.if_inst_pc, 32'h200);
    tick();

    // Byte store.
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 2'b00; bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h41;
    tick();
    chk("store_req", bus.dn_req, 1);
    chk("store_we", bus.dn_we, 1);
    chk("store_size", bus.dn_size, 2'b00);
    chk("store_addr", bus.dn_addr, 32'h30000);
    chk("store_wdata", bus.dn_wdata, 32'h41);
    bus.dn_done = 1;
    tick();
    bus.dn_done = 0; bus.ls_req = 0;
    chk("store_done", bus.ls_done, 1);
    tick();
    chk("store_done_pulse", bus.ls_done, 0);

    // Reset during an LSU access; a stray completion afterwards is ignored.
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'b11; bus.ls_addr = 32'h2000;
    tick();
    chk("rst_busy_issue", bus.dn_req, 1);
    rst = 1;
    tick();
    chk_all_zero("rst_mid");
    rst = 0; bus.ls_req = 0;
    bus.dn_done = 1; bus.dn_rdata = 32'hCAFE;
    tick();
    bus.dn_done = 0;
    chk("stray_no_ls_done", bus.ls_done, 0);
    chk("stray_no_dn_req", bus.dn_req, 0);
    tick();
    chk("stray_no_ls_done2", bus.ls_done, 0);

    // Randomized traffic against the transaction-level model.
    owner = 0; cd = 0; streak = 0; if_pend = 0; ls_pend = 0;
    exp_dn_req = 0; exp_if_ok = 0; exp_ls_done = 0;
    exp_we = 0; exp_size = 0; exp_addr = 0; exp_wdata = 0; own_pc = 0; own_size = 0;
    exp_inst = 0; exp_inst_pc = 0; exp_rdata = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_dn_req", bus.dn_req, exp_dn_req);
      if (exp_dn_req) begin
        chk("rnd_dn_addr", bus.dn_addr, exp_addr);
        chk("rnd_dn_we", bus.dn_we, exp_we);
        chk("rnd_dn_size", bus.dn_size, exp_size);
        if (owner == 2) chk("rnd_dn_wdata", bus.dn_wdata, exp_wdata);
      end
      chk("rnd_if_ok", bus.if_ok, exp_if_ok);
      if (exp_if_ok) begin
        chk("rnd_if_inst", bus.if_inst, exp_inst);
        chk("rnd_if_inst_pc", bus.if_inst_pc, exp_inst_pc);
      end
      chk("rnd_ls_done", bus.ls_done, exp_ls_done);
      if (exp_ls_done) chk("rnd_ls_rdata", bus.ls_rdata, exp_rdata);

      if (exp_if_ok) if_pend = 0;
      if (exp_ls_done) ls_pend = 0;
      if (!if_pend && $urandom_range(0, 3) == 0) begin
        if_pend = 1;
        bus.if_pc = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1;
        bus.ls_we = 1'($urandom);
        bus.ls_size = 2'($urandom);
        bus.ls_addr = $urandom;
        bus.ls_wdata = $urandom;
      end
      bus.if_req = if_pend;
      bus.ls_req = ls_pend;

      bus.dn_done = 0;
      if (owner != 0) begin
        if (cd == 0) begin
          bus.dn_done = 1;
          bus.dn_rdata = $urandom;
        end else cd--;
      end

      exp_dn_req = 0; exp_if_ok = 0; exp_ls_done = 0; granted = 0;
      if (owner == 0) begin
        if (ls_pend && !(if_pend && streak == LIMIT)) granted = 2;
        else if (if_pend) granted = 1;
        if (granted == 2) begin
          exp_we = bus.ls_we; exp_addr = bus.ls_addr; exp_wdata = bus.ls_wdata;
          exp_size = (bus.ls_size == 2'b10) ? 2'b11 : bus.ls_size;
          own_size = exp_size;
        end else if (granted == 1) begin
          exp_we = 0; exp_addr = bus.if_pc; exp_size = 2'b11;
          own_pc = bus.if_pc;
        end
        if (granted != 0) begin
          exp_dn_req = 1;
          owner = granted;
          cd = $urandom_range(0, 4);
        end
      end else if (bus.dn_done) begin
        if (owner == 1) begin
          exp_if_ok = 1; exp_inst = bus.dn_rdata; exp_inst_pc = own_pc;
        end else begin
          mask = (own_size == 2'b00) ? 32'hFF : (own_size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
          exp_ls_done = 1; exp_rdata = bus.dn_rdata & mask;
        end
        owner = 0;
      end
      if (!if_pend || granted == 1) streak = 0;
      else if (granted == 2 && streak < LIMIT) streak++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
